tft_parallel_driver: RTL and testbench

//  ILI9341 8-bit 8080-style parallel bus controller. It sits directly downstream of the

---
 rtl/tft_parallel_driver.sv | 346 ++++++++++++++++++++++++++++++++++
 tb/tb_tft_parallel_driver.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tft_parallel_driver.sv
// ILI9341 8-bit 8080-style parallel bus controller.
// Takes care of the panel power-up reset, the controller init sequence and the
// full-screen (240x320) window setup. After that it turns one-cycle RGB565 pixel
// strobes into two WRX-strobed data bytes.
//
// Optional feature: define TFT_DROP_COUNT_EN to add the drop_cnt output. It counts
// pixel strobes that arrive while the bus is busy.
//
// Ports:
//   clk_i        system clock
//   rst_i        asynchronous, active-high reset
//   reset_cursor 1-cycle pulse: re-issue the window and restart the RAM write at (0,0)
//   pix_data     RGB565 pixel, sampled only in the pix_clk cycle
//   pix_clk      1-cycle pixel strobe, honoured only while busy == 0
//   busy         1 = strobes are ignored (init, window setup or byte in flight)
//   nreset       LCD RESX, active low
//   cmd_data     LCD D/CX: 0 = command byte, 1 = parameter/pixel byte
//   write_edge   LCD WRX; the panel latches dout on the rising edge
//   dout         LCD data bus
//   drop_cnt     saturating count of ignored strobes (TFT_DROP_COUNT_EN only)
module tft_parallel_driver #(
  parameter int unsigned CLK_HZ            = 16000000,
  parameter int unsigned RST_LOW_CYCLES    = 160,
  parameter int unsigned RST_WAIT_CYCLES   = 1920000,
  parameter int unsigned SLEEP_WAIT_CYCLES = 1920000,
  parameter int unsigned WR_LOW_CYCLES     = 1,
  parameter int unsigned WR_HIGH_CYCLES    = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        reset_cursor,
  input  logic [15:0] pix_data,
  input  logic        pix_clk,
  output logic        busy,
  output logic        nreset,
  output logic        cmd_data,
  output logic        write_edge,
  output logic [7:0]  dout
`ifdef TFT_DROP_COUNT_EN
  ,
  output logic [7:0]  drop_cnt
`endif
);

  localparam int unsigned CNT_W = 21;
  localparam int unsigned IDX_W = 5;

  // Combined ROM layout: entries 0..6 are init, 7..17 are the window setup
  localparam logic [IDX_W-1:0] SLPOUT_IDX = IDX_W'(1);
  localparam logic [IDX_W-1:0] WIN_FIRST  = IDX_W'(7);
  localparam logic [IDX_W-1:0] ROM_LAST   = IDX_W'(17);

  localparam logic [CNT_W-1:0] RST_LOW_LAST    = CNT_W'(RST_LOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_WAIT_LAST   = CNT_W'(RST_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLEEP_WAIT_LAST = CNT_W'(SLEEP_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] WR_LOW_LAST     = CNT_W'(WR_LOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] WR_HIGH_LAST    = CNT_W'(WR_HIGH_CYCLES - 1);

  localparam logic [2:0] ST_RST_LOW    = 3'd0;
  localparam logic [2:0] ST_RST_WAIT   = 3'd1;
  localparam logic [2:0] ST_INIT       = 3'd2;
  localparam logic [2:0] ST_SLEEP_WAIT = 3'd3;
  localparam logic [2:0] ST_WINDOW     = 3'd4;
  localparam logic [2:0] ST_IDLE       = 3'd5;
  localparam logic [2:0] ST_PIXEL      = 3'd6;

  // Reject parameter sets the 21-bit counters or the byte sequencer cannot honour
  if (CLK_HZ == 0 || WR_LOW_CYCLES < 1 || WR_HIGH_CYCLES < 1 ||
      RST_LOW_CYCLES < 1 || RST_WAIT_CYCLES < 1 || SLEEP_WAIT_CYCLES < 1) begin : g_bad_zero
    $error("tft_parallel_driver: clock and cycle parameters must be >= 1");
  end
  if (RST_LOW_CYCLES > 2097151 || RST_WAIT_CYCLES > 2097151 ||
      SLEEP_WAIT_CYCLES > 2097151 || WR_LOW_CYCLES > 2097151 ||
      WR_HIGH_CYCLES > 2097151) begin : g_bad_range
    $error("tft_parallel_driver: cycle parameters exceed the 21-bit counters");
  end

  // ROM entry = {is_data, byte}
  function automatic logic [8:0] rom_entry(input logic [IDX_W-1:0] idx);
    logic [8:0] v;
    case (idx)
      5'd0:    v = {1'b0, 8'h01};  // SWRESET
      5'd1:    v = {1'b0, 8'h11};  // SLPOUT
      5'd2:    v = {1'b0, 8'h3A};  // COLMOD
      5'd3:    v = {1'b1, 8'h55};  // 16 bpp
      5'd4:    v = {1'b0, 8'h36};  // MADCTL
      5'd5:    v = {1'b1, 8'h48};
      5'd6:    v = {1'b0, 8'h29};  // DISPON
      5'd7:    v = {1'b0, 8'h2A};  // CASET 0..239
      5'd8:    v = {1'b1, 8'h00};
      5'd9:    v = {1'b1, 8'h00};
      5'd10:   v = {1'b1, 8'h00};
      5'd11:   v = {1'b1, 8'hEF};
      5'd12:   v = {1'b0, 8'h2B};  // PASET 0..319
      5'd13:   v = {1'b1, 8'h00};
      5'd14:   v = {1'b1, 8'h00};
      5'd15:   v = {1'b1, 8'h01};
      5'd16:   v = {1'b1, 8'h3F};
      5'd17:   v = {1'b0, 8'h2C};  // RAMWR
      default: v = 9'h000;
    endcase
    return v;
  endfunction

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic             r_in_byte;
  logic             r_pix_second;
  logic [7:0]       r_pix_lo;
  logic             r_pend;
  logic             r_busy;
  logic             r_nreset;
  logic             r_cmd_data;
  logic             r_write_edge;
  logic [7:0]       r_dout;

  logic [2:0]       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [IDX_W-1:0] w_idx_nxt;
  logic             w_in_byte_nxt;
  logic             w_pix_second_nxt;
  logic [7:0]       w_pix_lo_nxt;
  logic             w_pend_nxt;
  logic             w_nreset_nxt;
  logic             w_cmd_data_nxt;
  logic             w_write_edge_nxt;
  logic [7:0]       w_dout_nxt;
  logic             w_launch;
  logic [8:0]       w_launch_val;
  logic             w_pend;
  logic             w_byte_done;

  // Last high-phase cycle of the byte in flight; the next byte may launch right after it
  assign w_byte_done = r_in_byte && r_write_edge && (r_cnt == WR_HIGH_LAST);

  // A cursor request arriving mid-byte is held until the byte boundary
  assign w_pend = r_pend || (reset_cursor && (r_state == ST_WINDOW || r_state == ST_PIXEL));

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_idx_nxt        = r_idx;
    w_in_byte_nxt    = r_in_byte;
    w_pix_second_nxt = r_pix_second;
    w_pix_lo_nxt     = r_pix_lo;
    w_pend_nxt       = w_pend;
    w_nreset_nxt     = r_nreset;
    w_cmd_data_nxt   = r_cmd_data;
    w_write_edge_nxt = r_write_edge;
    w_dout_nxt       = r_dout;
    w_launch         = 1'b0;
    w_launch_val     = 9'h000;

    // Byte sub-sequencer: low phase, then high phase
    if (r_in_byte) begin
      if (!r_write_edge) begin
        if (r_cnt == WR_LOW_LAST) begin
          w_write_edge_nxt = 1'b1;
          w_cnt_nxt        = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end else if (!w_byte_done) begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
    end

    case (r_state)
      ST_RST_LOW: begin
        if (r_cnt == RST_LOW_LAST) begin
          w_state_nxt  = ST_RST_WAIT;
          w_cnt_nxt    = '0;
          w_nreset_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      ST_RST_WAIT: begin
        if (r_cnt == RST_WAIT_LAST) begin
          w_state_nxt  = ST_INIT;
          w_idx_nxt    = '0;
          w_launch     = 1'b1;
          w_launch_val = rom_entry('0);
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      ST_INIT, ST_WINDOW: begin
        if (w_byte_done) begin
          if (r_idx == SLPOUT_IDX) begin
            w_state_nxt   = ST_SLEEP_WAIT;
            w_idx_nxt     = r_idx + IDX_W'(1);
            w_in_byte_nxt = 1'b0;
            w_cnt_nxt     = '0;
          end else if (r_state == ST_WINDOW && w_pend) begin
            w_idx_nxt    = WIN_FIRST;
            w_launch     = 1'b1;
            w_launch_val = rom_entry(WIN_FIRST);
            w_pend_nxt   = 1'b0;
          end else if (r_idx == ROM_LAST) begin
            w_state_nxt   = ST_IDLE;
            w_in_byte_nxt = 1'b0;
          end else begin
            w_idx_nxt    = r_idx + IDX_W'(1);
            w_launch     = 1'b1;
            w_launch_val = rom_entry(r_idx + IDX_W'(1));
            if (r_idx + IDX_W'(1) == WIN_FIRST) begin
              w_state_nxt = ST_WINDOW;
            end
          end
        end
      end

      ST_SLEEP_WAIT: begin
        if (r_cnt == SLEEP_WAIT_LAST) begin
          w_state_nxt  = ST_INIT;
          w_launch     = 1'b1;
          w_launch_val = rom_entry(r_idx);
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      ST_IDLE: begin
        // reset_cursor wins over a simultaneous pixel strobe
        if (reset_cursor) begin
          w_state_nxt  = ST_WINDOW;
          w_idx_nxt    = WIN_FIRST;
          w_launch     = 1'b1;
          w_launch_val = rom_entry(WIN_FIRST);
        end else if (pix_clk) begin
          w_state_nxt      = ST_PIXEL;
          w_launch         = 1'b1;
          w_launch_val     = {1'b1, pix_data[15:8]};
          w_pix_lo_nxt     = pix_data[7:0];
          w_pix_second_nxt = 1'b0;
        end
      end

      ST_PIXEL: begin
        if (w_byte_done) begin
          if (w_pend) begin
            w_state_nxt  = ST_WINDOW;
            w_idx_nxt    = WIN_FIRST;
            w_launch     = 1'b1;
            w_launch_val = rom_entry(WIN_FIRST);
            w_pend_nxt   = 1'b0;
          end else if (!r_pix_second) begin
            w_launch         = 1'b1;
            w_launch_val     = {1'b1, r_pix_lo};
            w_pix_second_nxt = 1'b1;
          end else begin
            w_state_nxt   = ST_IDLE;
            w_in_byte_nxt = 1'b0;
          end
        end
      end

      default: begin
        w_state_nxt      = ST_RST_LOW;
        w_cnt_nxt        = '0;
        w_in_byte_nxt    = 1'b0;
        w_pend_nxt       = 1'b0;
        w_nreset_nxt     = 1'b0;
        w_write_edge_nxt = 1'b1;
      end
    endcase

    // Start a new byte: drive bus and D/CX, drop WRX
    if (w_launch) begin
      w_dout_nxt       = w_launch_val[7:0];
      w_cmd_data_nxt   = w_launch_val[8];
      w_write_edge_nxt = 1'b0;
      w_cnt_nxt        = '0;
      w_in_byte_nxt    = 1'b1;
    end
  end

  // State and output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= ST_RST_LOW;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_in_byte    <= 1'b0;
      r_pix_second <= 1'b0;
      r_pix_lo     <= '0;
      r_pend       <= 1'b0;
      r_busy       <= 1'b1;
      r_nreset     <= 1'b0;
      r_cmd_data   <= 1'b0;
      r_write_edge <= 1'b1;
      r_dout       <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_idx        <= w_idx_nxt;
      r_in_byte    <= w_in_byte_nxt;
      r_pix_second <= w_pix_second_nxt;
      r_pix_lo     <= w_pix_lo_nxt;
      r_pend       <= w_pend_nxt;
      r_busy       <= (w_state_nxt != ST_IDLE);
      r_nreset     <= w_nreset_nxt;
      r_cmd_data   <= w_cmd_data_nxt;
      r_write_edge <= w_write_edge_nxt;
      r_dout       <= w_dout_nxt;
    end
  end

  assign busy       = r_busy;
  assign nreset     = r_nreset;
  assign cmd_data   = r_cmd_data;
  assign write_edge = r_write_edge;
  assign dout       = r_dout;

`ifdef TFT_DROP_COUNT_EN
  logic [7:0] r_drop_cnt;
  logic [7:0] w_drop_cnt_nxt;

  // Only strobes lost to window setup or pixel transfer are counted
  always_comb begin
    w_drop_cnt_nxt = r_drop_cnt;
    if (r_state == ST_IDLE && reset_cursor) begin
      w_drop_cnt_nxt = '0;
    end else if (pix_clk && r_busy && (r_state == ST_WINDOW || r_state == ST_PIXEL) &&
                 r_drop_cnt != 8'hFF) begin
      w_drop_cnt_nxt = r_drop_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_drop_cnt <= '0;
    end else begin
      r_drop_cnt <= w_drop_cnt_nxt;
    end
  end

  assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_tft_parallel_driver.sv
// Self-checking bench for tft_parallel_driver: bus log of every WRX rising edge
// compared against the expected command/parameter/pixel byte stream.
module tb_tft_parallel_driver;

  localparam int unsigned RST_LOW    = 4;
  localparam int unsigned RST_WAIT   = 20;
  localparam int unsigned SLEEP_WAIT = 20;
  localparam int unsigned WR_L       = 1;
  localparam int unsigned WR_H       = 1;
  localparam int unsigned BYTE_P     = WR_L + WR_H;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        reset_cursor;
  logic [15:0] pix_data;
  logic        pix_clk;
  logic        busy;
  logic        nreset;
  logic        cmd_data;
  logic        write_edge;
  logic [7:0]  dout;
`ifdef TFT_DROP_COUNT_EN
  logic [7:0]  drop_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int exp_drop = 0;

  logic [8:0] log_q[$];
  int         log_t[$];
  logic [8:0] exp_q[$];
  logic       prev_we = 1'b1;
  logic [8:0] fall_val = 9'h000;

  tft_parallel_driver #(
    .CLK_HZ           (16000000),
    .RST_LOW_CYCLES   (RST_LOW),
    .RST_WAIT_CYCLES  (RST_WAIT),
    .SLEEP_WAIT_CYCLES(SLEEP_WAIT),
    .WR_LOW_CYCLES    (WR_L),
    .WR_HIGH_CYCLES   (WR_H)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .reset_cursor(reset_cursor),
    .pix_data    (pix_data),
    .pix_clk     (pix_clk),
    .busy        (busy),
    .nreset      (nreset),
    .cmd_data    (cmd_data),
    .write_edge  (write_edge),
    .dout        (dout)
`ifdef TFT_DROP_COUNT_EN
    ,
    .drop_cnt    (drop_cnt)
`endif
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Panel-side view: log each byte at WRX rise, bus must hold its value since the fall
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (prev_we && !write_edge) fall_val = {cmd_data, dout};
      if (!prev_we && write_edge) begin
        chk("bus_stable", 32'({cmd_data, dout}), 32'(fall_val));
        log_q.push_back({cmd_data, dout});
        log_t.push_back(cyc);
      end
    end
    prev_we = write_edge;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_init();
    exp_q.push_back(9'h001); exp_q.push_back(9'h011); exp_q.push_back(9'h03A);
    exp_q.push_back(9'h155); exp_q.push_back(9'h036); exp_q.push_back(9'h148);
    exp_q.push_back(9'h029);
  endtask

  task automatic push_window();
    exp_q.push_back(9'h02A); exp_q.push_back(9'h100); exp_q.push_back(9'h100);
    exp_q.push_back(9'h100); exp_q.push_back(9'h1EF);
    exp_q.push_back(9'h02B); exp_q.push_back(9'h100); exp_q.push_back(9'h100);
    exp_q.push_back(9'h101); exp_q.push_back(9'h13F);
    exp_q.push_back(9'h02C);
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_len"}, 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      chk(tag, 32'(log_q[i]), 32'(exp_q[i]));
    log_q.delete();
    log_t.delete();
    exp_q.delete();
  endtask

  task automatic check_drop();
`ifdef TFT_DROP_COUNT_EN
    chk("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
`endif
  endtask

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < max_cyc) begin
      tick();
      n++;
    end
    if (busy !== 1'b0) chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  // One accepted pixel; optionally an ignored strobe inj_k cycles after acceptance
  task automatic do_pixel(input logic [15:0] v, input int inj_k, input logic [15:0] inj_v);
    int t;
    pix_data = v;
    pix_clk  = 1'b1;
    t        = cyc;
    tick();
    pix_clk  = 1'b0;
    pix_data = 16'($urandom);
    exp_q.push_back({1'b1, v[15:8]});
    exp_q.push_back({1'b1, v[7:0]});
    for (int k = 1; k <= int'(2 * BYTE_P); k++) begin
      chk("busy_hi", 32'(busy), 32'd1);
      if (k == inj_k) begin
        pix_clk  = 1'b1;
        pix_data = inj_v;
        exp_drop = (exp_drop < 255) ? exp_drop + 1 : 255;
      end
      tick();
      pix_clk = 1'b0;
    end
    chk("busy_lo", 32'(busy), 32'd0);
    if (log_t.size() == 2) begin
      chk("rise0_t", 32'(log_t[0] - t), 32'(1 + WR_L));
      chk("rise1_t", 32'(log_t[1] - t), 32'(1 + WR_L + BYTE_P));
    end
    check_log("pix");
    check_drop();
  endtask

  initial begin
    int nlow;
    logic [15:0] v;
    rst_i        = 1'b1;
    reset_cursor = 1'b0;
    pix_clk      = 1'b0;
    pix_data     = 16'h0000;
    repeat (3) tick();

    chk("rst_nreset", 32'(nreset), 32'd0);
    chk("rst_cmd_data", 32'(cmd_data), 32'd0);
    chk("rst_write_edge", 32'(write_edge), 32'd1);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    check_drop();

    // Power-up: reset pulse, init ROM, window setup
    rst_i = 1'b0;
    nlow  = 0;
    while (nreset === 1'b0 && nlow < 100) begin
      nlow++;
      tick();
    end
    chk("nreset_low_cycles", 32'(nlow), 32'(RST_LOW));
    wait_idle(2000);
    if (log_t.size() >= 3)
      chk("slpout_gap", 32'((log_t[2] - log_t[1]) >= int'(SLEEP_WAIT)), 32'd1);
    else
      chk("slpout_gap_bytes", 32'(log_t.size()), 32'd3);
    push_init();
    push_window();
    check_log("init");

    // Pixel F81F with an ignored 1234 strobe two cycles after acceptance
    tick();
    do_pixel(16'hF81F, 2, 16'h1234);

    // Cursor reset and pixel strobe together: window only
    reset_cursor = 1'b1;
    pix_clk      = 1'b1;
    pix_data     = 16'hABCD;
    tick();
    reset_cursor = 1'b0;
    pix_clk      = 1'b0;
    exp_drop     = 0;
    chk("rc_busy", 32'(busy), 32'd1);
    wait_idle(200);
    push_window();
    check_log("rc_pix");
    check_drop();

    // Cursor reset during the high byte: high byte, then full window, no low byte
    pix_data = 16'h5AA5;
    pix_clk  = 1'b1;
    tick();
    pix_clk      = 1'b0;
    reset_cursor = 1'b1;
    tick();
    reset_cursor = 1'b0;
    wait_idle(200);
    exp_q.push_back(9'h15A);
    push_window();
    check_log("rc_mid");
    check_drop();

    // Random traffic: pixels, ignored strobes, occasional cursor resets
    for (int it = 0; it < 40; it++) begin
      int r;
      repeat ($urandom_range(0, 3)) tick();
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        reset_cursor = 1'b1;
        tick();
        reset_cursor = 1'b0;
        exp_drop     = 0;
        wait_idle(200);
        push_window();
        check_log("rnd_rc");
        check_drop();
      end else begin
        v = 16'($urandom);
        do_pixel(v, (r < 5) ? int'($urandom_range(1, 2 * BYTE_P)) : 0, 16'($urandom));
      end
    end

    // Asynchronous reset in the middle of a byte
    pix_data = 16'hC3C3;
    pix_clk  = 1'b1;
    tick();
    pix_clk = 1'b0;
    chk("pre_rst_we", 32'(write_edge), 32'd0);
    #1;
    rst_i = 1'b1;
    #1;
    chk("arst_write_edge", 32'(write_edge), 32'd1);
    chk("arst_nreset", 32'(nreset), 32'd0);
    chk("arst_busy", 32'(busy), 32'd1);
    repeat (2) tick();
    log_q.delete();
    log_t.delete();
    exp_q.delete();
    exp_drop = 0;
    check_drop();
    rst_i = 1'b0;
    wait_idle(2000);
    push_init();
    push_window();
    check_log("reinit");

    tick();
    do_pixel(16'h0F0F, 0, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
